// File: rtl/wm_pkg.sv
// Shared types and duration tables for the wash-cycle sequencer.
package wm_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_RINSE = 3'd4,
    PH_SPIN  = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2,
    PROG_RSVD   = 2'd3
  } prog_e;

  localparam int DUR_W = 8;

  // Phase length in ticks; the reserved program code runs as normal.
  function automatic logic [DUR_W-1:0] phase_dur(input prog_e p, input phase_e ph);
    logic [DUR_W-1:0] d_q, d_n, d_h;
    d_q = '0;
    d_n = '0;
    d_h = '0;
    case (ph)
      PH_FILL:  begin d_q = 8'd3; d_n = 8'd4;  d_h = 8'd5;  end
      PH_WASH:  begin d_q = 8'd5; d_n = 8'd10; d_h = 8'd15; end
      PH_DRAIN: begin d_q = 8'd2; d_n = 8'd3;  d_h = 8'd4;  end
      PH_RINSE: begin d_q = 8'd3; d_n = 8'd5;  d_h = 8'd6;  end
      PH_SPIN:  begin d_q = 8'd4; d_n = 8'd6;  d_h = 8'd8;  end
      default:  ;
    endcase
    case (p)
      PROG_QUICK: phase_dur = d_q;
      PROG_HEAVY: phase_dur = d_h;
      default:    phase_dur = d_n;
    endcase
  endfunction

  // Number of rinse passes per program.
  function automatic logic [1:0] rinse_reps(input prog_e p);
    case (p)
      PROG_QUICK: rinse_reps = 2'd1;
      PROG_HEAVY: rinse_reps = 2'd3;
      default:    rinse_reps = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-cycle phase tick every TICK_DIV enabled cycles.
module wm_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_max;

  assign at_max = (cnt_q == CW'(TICK_DIV - 1));
  // Clear dominates so a freshly loaded phase always starts a full tick period.
  assign tick   = enable && !clear && at_max;

  // Next count: clear, wrap at terminal count, or advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = at_max ? '0 : cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wm_cycle_sequencer.sv
// Wash-cycle sequencer: FILL, WASH, DRAIN, RINSE loop, SPIN, DONE.
// Optional abort feature: define WM_ABORT_EN to add abort_button.
//
// state    | meaning
// IDLE     | waiting for a start edge
// FILL     | valve open
// WASH     | motor slow
// DRAIN    | pump running
// RINSE    | motor slow, loops back to DRAIN
// SPIN     | motor fast with pump
// DONE     | one-cycle completion pulse
module wm_cycle_sequencer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_button,
  input  logic             pause_button,
  input  logic [1:0]       prog,
`ifdef WM_ABORT_EN
  input  logic             abort_button,
`endif
  output logic             valve_on,
  output logic             motor_on,
  output logic             motor_fast,
  output logic             pump_on,
  output logic             door_lock,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done
);

  phase_e           phase_q, phase_d, next_ph;
  prog_e            prog_q, prog_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       rinse_cnt_q, rinse_cnt_d;
  logic             aborting_q, aborting_d;
  logic             start_q, pause_q;
  logic             active, run, start_edge, tick, pre_clear;
  logic             abort_jump, abort_drain;

  assign active     = phase_q inside {PH_FILL, PH_WASH, PH_DRAIN, PH_RINSE, PH_SPIN};
  assign run        = active && !pause_q;
  assign start_edge = start_button && !start_q;

`ifdef WM_ABORT_EN
  assign abort_jump  = abort_button && (phase_q inside {PH_FILL, PH_WASH, PH_RINSE, PH_SPIN});
  assign abort_drain = abort_button && (phase_q == PH_DRAIN);
`else
  assign abort_jump  = 1'b0;
  assign abort_drain = 1'b0;
`endif

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (run),
    .clear  (pre_clear),
    .tick   (tick)
  );

  // Next-state, countdown and rinse bookkeeping.
  always_comb begin
    phase_d     = phase_q;
    prog_d      = prog_q;
    remaining_d = remaining_q;
    rinse_cnt_d = rinse_cnt_q;
    aborting_d  = aborting_q || abort_drain;
    pre_clear   = 1'b0;

    case (phase_q)
      PH_FILL:  next_ph = PH_WASH;
      PH_WASH:  next_ph = PH_DRAIN;
      PH_DRAIN: begin
        if (aborting_q || abort_drain)             next_ph = PH_IDLE;
        else if (rinse_cnt_q < rinse_reps(prog_q)) next_ph = PH_RINSE;
        else                                       next_ph = PH_SPIN;
      end
      PH_RINSE: next_ph = PH_DRAIN;
      PH_SPIN:  next_ph = PH_DONE;
      default:  next_ph = PH_IDLE;
    endcase

    if (phase_q == PH_IDLE) begin
      pre_clear = 1'b1;
      if (start_edge) begin
        prog_d      = prog_e'(prog);
        rinse_cnt_d = '0;
        aborting_d  = 1'b0;
        remaining_d = CNT_W'(phase_dur(prog_e'(prog), PH_FILL));
        phase_d     = PH_FILL;
      end
    end else if (!active) begin
      // DONE and the unused code both fall back to IDLE.
      pre_clear = 1'b1;
      phase_d   = PH_IDLE;
    end else if (abort_jump) begin
      // Abort is not gated by pause so the drain starts at once.
      pre_clear   = 1'b1;
      aborting_d  = 1'b1;
      phase_d     = PH_DRAIN;
      remaining_d = CNT_W'(phase_dur(prog_q, PH_DRAIN));
    end else if (tick) begin
      if (remaining_q == CNT_W'(1)) begin
        phase_d     = next_ph;
        remaining_d = CNT_W'(phase_dur(prog_q, next_ph));
        if (phase_q == PH_RINSE) rinse_cnt_d = rinse_cnt_q + 2'd1;
      end else begin
        remaining_d = remaining_q - CNT_W'(1);
      end
    end
  end

  // State registers and button synchronising flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= PH_IDLE;
      prog_q      <= PROG_NORMAL;
      remaining_q <= '0;
      rinse_cnt_q <= '0;
      aborting_q  <= 1'b0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      prog_q      <= prog_d;
      remaining_q <= remaining_d;
      rinse_cnt_q <= rinse_cnt_d;
      aborting_q  <= aborting_d;
      start_q     <= start_button;
      pause_q     <= pause_button;
    end
  end

  // Moore output decode; pause drops every actuator except the door lock.
  always_comb begin
    valve_on   = run && (phase_q == PH_FILL);
    motor_on   = run && (phase_q inside {PH_WASH, PH_RINSE, PH_SPIN});
    motor_fast = run && (phase_q == PH_SPIN);
    pump_on    = run && (phase_q inside {PH_DRAIN, PH_SPIN});
    door_lock  = active;
    busy       = active;
    done       = (phase_q == PH_DONE);
    phase      = phase_q;
    remaining  = active ? remaining_q : '0;
  end

endmodule
